// File: rtl/rv_mem_imm_unit.sv
// -----------------------------------------------------------------------------
// rv_mem_imm_unit
//   Memory and immediate subsystem of a single-cycle RV32I datapath.
//   - Instruction ROM: 64 words, combinational read at inst_addr (PC[7:2]).
//   - Data RAM: 64 words, synchronous full-word write and combinational read
//     at data_addr (ALU[7:2]). Asynchronous reset loads a small boot image.
//   - Immediate generator: combinational, decoded from imm_inst[6:0].
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   inst_addr  in   6   instruction word address
//   instr      out  32  instruction word at inst_addr
//   mem_read   in   1   data read enable (data_out is 0 when low)
//   mem_write  in   1   data write enable
//   data_addr  in   6   data word address
//   data_in    in   32  write data
//   data_out   out  32  read data
//   imm_inst   in   32  instruction presented to the immediate generator
//   imm_out    out  32  generated immediate (B/J results in halfword units)
// -----------------------------------------------------------------------------
module rv_mem_imm_unit #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] inst_addr,
    output logic [WIDTH-1:0]         instr,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [$clog2(DEPTH)-1:0] data_addr,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    input  logic [31:0]              imm_inst,
    output logic [31:0]              imm_out
);

    // Opcodes recognised by the immediate generator.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Boot values of the first two data words.
    localparam logic [WIDTH-1:0] RAM_INIT_W0 = WIDTH'(17);
    localparam logic [WIDTH-1:0] RAM_INIT_W1 = WIDTH'(9);

    localparam logic [WIDTH-1:0] NOP_WORD = WIDTH'(32'h0000_0033);

    // -------------------------------------------------------------------------
    // Instruction ROM
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_rom_word;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned; an unassigned path infers a latch.
    always_comb begin
        w_rom_word = NOP_WORD;
        case (inst_addr)
            6'd0:    w_rom_word = WIDTH'(32'h0000_2083); // lw  x1,0(x0)
            6'd1:    w_rom_word = WIDTH'(32'h0040_2103); // lw  x2,4(x0)
            6'd2:    w_rom_word = WIDTH'(32'h0020_81B3); // add x3,x1,x2
            6'd3:    w_rom_word = WIDTH'(32'h0030_2423); // sw  x3,8(x0)
            6'd4:    w_rom_word = WIDTH'(32'h0000_0063); // beq x0,x0,0
            default: w_rom_word = NOP_WORD;               // add x0,x0,x0
        endcase
    end

    assign instr = w_rom_word;

    // -------------------------------------------------------------------------
    // Data RAM
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_ram [DEPTH];

    // NOTE: this array is reset, so it maps to flops rather than a RAM macro;
    // that is intentional because the boot image must appear asynchronously.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= '0;
            end
            r_ram[0] <= RAM_INIT_W0;
            r_ram[1] <= RAM_INIT_W1;
        end else if (mem_write) begin
            r_ram[data_addr] <= data_in;
        end
    end

    // Combinational read: a same-address write shows up only after the edge.
    assign data_out = mem_read ? r_ram[data_addr] : '0;

    // -------------------------------------------------------------------------
    // Immediate generator
    // -------------------------------------------------------------------------
    logic [31:0] w_imm;

    always_comb begin
        w_imm = 32'h0;
        case (imm_inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                w_imm = {{20{imm_inst[31]}}, imm_inst[31:20]};
            OP_STORE:
                w_imm = {{20{imm_inst[31]}}, imm_inst[31:25], imm_inst[11:7]};
            // Branch and jump offsets stay in halfword units; the downstream
            // shifter appends the implicit zero LSB.
            OP_BRANCH:
                w_imm = {{20{imm_inst[31]}}, imm_inst[31], imm_inst[7],
                         imm_inst[30:25], imm_inst[11:8]};
            OP_JAL:
                w_imm = {{12{imm_inst[31]}}, imm_inst[31], imm_inst[19:12],
                         imm_inst[20], imm_inst[30:21]};
            OP_LUI, OP_AUIPC:
                w_imm = {imm_inst[31:12], 12'b0};
            default:
                w_imm = 32'h0;
        endcase
    end

    assign imm_out = w_imm;

endmodule

// File: tb/tb_rv_mem_imm_unit.sv
module tb_rv_mem_imm_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  inst_addr;
    logic [31:0] instr;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [31:0] imm_inst;
    logic [31:0] imm_out;

    int n_checks = 0;
    int n_errors = 0;

    rv_mem_imm_unit #(.DEPTH(64), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_addr (inst_addr),
        .instr     (instr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_addr (data_addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .imm_inst  (imm_inst),
        .imm_out   (imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference immediate: built from the field rules with signed arithmetic.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int s;
        int u;
        s = $signed(ins);
        u = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return 32'(s >>> 20);
            7'h23: return 32'(((s >>> 25) * 32) + int'(ins[11:7]));
            7'h63: begin
                u = ((s >>> 31) * 2048) + int'(ins[7]) * 1024
                    + int'(ins[30:25]) * 16 + int'(ins[11:8]);
                return 32'(u);
            end
            7'h6F: begin
                u = ((s >>> 31) * 524288) + int'(ins[19:12]) * 2048
                    + int'(ins[20]) * 1024 + int'(ins[30:21]);
                return 32'(u);
            end
            7'h37, 7'h17: return (ins / 4096) * 4096;
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] exp;
    } rom_vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] exp;
    } imm_vec_t;

    rom_vec_t    rom_vecs [7];
    imm_vec_t    imm_vecs [7];
    logic [31:0] ram_m [64];
    logic [6:0]  opcodes [9];

    task automatic pulse_reset_midcycle();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; inst_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
        data_addr = '0; data_in = '0; imm_inst = '0;

        rom_vecs[0] = '{6'd0,  32'h0000_2083};
        rom_vecs[1] = '{6'd1,  32'h0040_2103};
        rom_vecs[2] = '{6'd2,  32'h0020_81B3};
        rom_vecs[3] = '{6'd3,  32'h0030_2423};
        rom_vecs[4] = '{6'd4,  32'h0000_0063};
        rom_vecs[5] = '{6'd5,  32'h0000_0033};
        rom_vecs[6] = '{6'd63, 32'h0000_0033};

        imm_vecs[0] = '{32'hFFF0_0293, 32'hFFFF_FFFF};
        imm_vecs[1] = '{32'h0030_2423, 32'h0000_0008};
        imm_vecs[2] = '{32'hFE00_0CE3, 32'hFFFF_FFFC};
        imm_vecs[3] = '{32'h1234_50B7, 32'h1234_5000};
        imm_vecs[4] = '{32'h0020_81B3, 32'h0000_0000};
        imm_vecs[5] = '{32'h8000_006F, 32'hFFF8_0000}; // jal, only sign bit set
        imm_vecs[6] = '{32'h7FF0_0067, 32'h0000_07FF}; // jalr, max positive

        opcodes = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};

        // ROM is live even while reset is held.
        for (int i = 0; i < 7; i++) begin
            inst_addr = rom_vecs[i].addr;
            #1 check($sformatf("rom[%0d]", rom_vecs[i].addr), instr, rom_vecs[i].exp);
        end

        #3 rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            imm_inst = imm_vecs[i].inst;
            #1 check($sformatf("imm 0x%08h", imm_vecs[i].inst), imm_out, imm_vecs[i].exp);
        end

        // Reset contents after a mid-cycle reset pulse.
        pulse_reset_midcycle();
        mem_read = 1'b1;
        data_addr = 6'd0; #1 check("reset w0", data_out, 32'd17);
        data_addr = 6'd1; #1 check("reset w1", data_out, 32'd9);
        data_addr = 6'd2; #1 check("reset w2", data_out, 32'd0);
        mem_read = 1'b0;
        data_addr = 6'd0; #1 check("read disabled", data_out, 32'd0);

        // Write then read back.
        @(negedge clk);
        mem_write = 1'b1; data_addr = 6'd2; data_in = 32'd26;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1;
        #1 check("write w2", data_out, 32'd26);
        data_in = 32'hDEAD;
        @(negedge clk);
        #1 check("no write w2", data_out, 32'd26);

        pulse_reset_midcycle();
        #1 check("reset clears w2", data_out, 32'd0);

        // Same-cycle read and write: old value before the edge, new after.
        @(negedge clk);
        data_addr = 6'd3; data_in = 32'hA5A5_A5A5; mem_write = 1'b1; mem_read = 1'b1;
        #1 check("rw before edge", data_out, 32'd0);
        @(posedge clk);
        #1 check("rw after edge", data_out, 32'hA5A5_A5A5);
        mem_write = 1'b0;

        // Reset asserted on the same edge as a write: reset wins.
        @(negedge clk);
        mem_write = 1'b1; data_addr = 6'd0; data_in = 32'd5;
        @(posedge clk);
        rst = 1'b0;
        #2 mem_write = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset beats write", data_out, 32'd17);

        // Randomized RAM traffic against an array model.
        for (int i = 0; i < 64; i++) ram_m[i] = '0;
        ram_m[0] = 32'd17;
        ram_m[1] = 32'd9;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            mem_write = ($urandom_range(0, 2) == 0);
            mem_read  = ($urandom_range(0, 3) != 0);
            data_addr = 6'($urandom_range(0, 63));
            data_in   = $urandom;
            #1 check("rand ram read", data_out, mem_read ? ram_m[data_addr] : 32'h0);
            @(posedge clk);
            if (mem_write) ram_m[data_addr] = data_in;
        end
        mem_write = 1'b0;

        // Randomized immediates across all formats.
        for (int n = 0; n < 300; n++) begin
            imm_inst = {$urandom_range(0, 32'h1FF_FFFF), 7'h0};
            imm_inst[6:0] = (n % 10 == 9) ? 7'($urandom) : opcodes[$urandom_range(0, 8)];
            #1 check("rand imm", imm_out, ref_imm(imm_inst));
        end

        // Randomized ROM addresses.
        for (int n = 0; n < 50; n++) begin
            inst_addr = 6'($urandom);
            #1 check("rand rom", instr,
                     (inst_addr < 6'd5) ? rom_vecs[inst_addr].exp : 32'h0000_0033);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_mem_imm_unit.md
Name: rv_mem_imm_unit

Overview:
- Memory and immediate subsystem of the single-cycle RV32I datapath.
- Contains three parts:
  - a 64-word instruction ROM, read combinationally from the word address taken from PC[7:2];
  - a 64-word data RAM, written synchronously and read combinationally from the word address taken from ALU[7:2];
  - a combinational immediate generator.
- Output feeds the ALU source mux, the branch shifter and the writeback mux.

Parameters:
- DEPTH, 64, words in each memory (address width 6).
- WIDTH, 32, data/instruction width in bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- inst_addr  input  6  instruction word address (PC[7:2]).
- instr  output  32  instruction word at inst_addr.
- mem_read  input  1  data-memory read enable.
- mem_write  input  1  data-memory write enable.
- data_addr  input  6  data word address (ALU result [7:2]).
- data_in  input  32  write data (rs2 value).
- data_out  output  32  read data.
- imm_inst  input  32  instruction word presented to the immediate generator.
- imm_out  output  32  generated immediate.

Behaviour:
- Instruction ROM: combinational, instr = rom[inst_addr]; unaffected by clk or rst. Fixed contents:
  - w0 = 0x00002083 (lw x1,0(x0))
  - w1 = 0x00402103 (lw x2,4(x0))
  - w2 = 0x002081B3 (add x3,x1,x2)
  - w3 = 0x00302423 (sw x3,8(x0))
  - w4 = 0x00000063 (beq x0,x0,0)
  - w5..w63 = 0x00000033 (nop add x0,x0,x0)
- Data RAM reset: when rst=0, immediately and asynchronously set w0 = 32'd17, w1 = 32'd9, all other words 0. Writes are ignored while rst is low.
- Data RAM write: on rising clk with rst=1 and mem_write=1, ram[data_addr] <= data_in. No byte or halfword lanes; full-word access only.
- Data RAM read: combinational, data_out = ram[data_addr] when mem_read=1, else 32'h0.
- Read and write to the same address in one cycle: data_out shows the old value until the edge and the new value after it.
- mem_read and mem_write both set: the write occurs and the read is still returned.
- Addresses wrap naturally within 6 bits; there are no out-of-range cases.
- Immediate generator (combinational), decoded on imm_inst[6:0]:
  - 0000011 / 0010011 / 1100111 (I-type): sign-extend imm_inst[31:20]. Shift-immediates use the same rule.
  - 0100011 (S-type): sign-extend {[31:25],[11:7]}.
  - 1100011 (B-type): sign-extend {[31],[7],[30:25],[11:8]}. The result is in halfword units; the downstream shifter supplies bit 0.
  - 1101111 (J-type): sign-extend {[31],[19:12],[20],[30:21]}, also in halfword units.
  - 0110111 / 0010111 (U-type): {[31:12],12'b0}.
  - any other opcode (R-type etc.): 32'h0.
- Latency: all reads and imm_out are zero-latency combinational; writes take effect at the next rising edge.

Test Plan:
- ROM read: sweep inst_addr 0..5 → instr = 0x00002083, 0x00402103, 0x002081B3, 0x00302423, 0x00000063, 0x00000033; inst_addr=63 → 0x00000033.
- Reset contents: pulse rst low asynchronously (mid-cycle, no clk edge), then mem_read=1 → data_out = 17 at addr 0, 9 at addr 1, 0 at addr 2. With mem_read=0 → data_out = 0.
- Write/read-back:
  - mem_write=1, addr=2, data_in=26, one clk edge → data_out (mem_read=1) = 26.
  - mem_write=0 with data_in=0xDEAD → addr 2 stays 26.
  - Assert rst low again → addr 2 returns to 0.
- Same-cycle read/write: addr=3 holds 0; set mem_write=1, mem_read=1, data_in=0xA5A5A5A5 → data_out = 0 before the edge, 0xA5A5A5A5 after.
- Immediates:
  - 0xFFF00293 → 0xFFFFFFFF
  - 0x00302423 → 0x00000008
  - 0xFE000CE3 → 0xFFFFFFFC
  - 0x123450B7 → 0x12345000
  - 0x002081B3 → 0x00000000
- Reset during write: rst low coincident with a clk edge where mem_write=1, addr=0, data_in=5 → addr 0 reads 17 (reset dominates).
